// File: rtl/key_display_pkg.sv
// Shared definitions for the key display scheduler: FSM state codes, blank code, helpers.
package key_display_pkg;

    localparam int CODE_W = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SHOW = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    localparam logic [CODE_W-1:0] BLANK_CODE = 7'b0;

    function automatic logic is_onehot(input logic [CODE_W-1:0] code);
        return (code != '0) && ((code & (code - CODE_W'(1))) == '0);
    endfunction

    // Width for a down-counter that must hold max(hold, gap) - 1; never below one bit.
    function automatic int timer_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// DEPTH x 7 code queue with registered occupancy count; pointers wrap modulo DEPTH.
module key_fifo
    import key_display_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [CODE_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [CODE_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              push_ok, pop_ok;

    // Guards make over/underflow impossible even if a caller misbehaves.
    assign push_ok = push_i && (count_q != (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/key_display_scheduler.sv
// Queues one-hot key codes and shows each for HOLD_CYCLES, followed by GAP_CYCLES of blank.
// state | meaning
// IDLE  | queue empty, display blank
// SHOW  | current code on disp_data, timer counting the hold
// GAP   | display blank, timer counting the gap
module key_display_scheduler
    import key_display_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [CODE_W-1:0]        in_data,
    output logic                     in_ready,
    output logic [CODE_W-1:0]        disp_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err
);

    localparam int TW = timer_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CODE_W-1:0] disp_q, disp_d, head;
    logic              busy_q, busy_d, err_q, err_d;
    logic              accept, push, pop;
    logic [PW-1:0]     count;

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (in_data),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

    assign in_ready = (count < PW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_onehot(in_data);
    assign err_d    = accept && !is_onehot(in_data);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        disp_d  = disp_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    disp_d  = head;
                    timer_d = HOLD_LD;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (timer_q == '0) begin
                    disp_d  = BLANK_CODE;
                    timer_d = GAP_LD;
                    state_d = ST_GAP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (count != '0) begin
                    // Chain straight into the next code without passing through IDLE.
                    pop     = 1'b1;
                    disp_d  = head;
                    timer_d = HOLD_LD;
                    state_d = ST_SHOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                disp_d  = BLANK_CODE;
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            disp_q  <= BLANK_CODE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign disp_data = disp_q;
    assign busy      = busy_q;
    assign pending   = count;
    assign err       = err_q;

endmodule

// File: tb/tb_key_display_scheduler.sv
// Directed bench for key_display_scheduler with HOLD=4, GAP=2, DEPTH=4.
module tb_key_display_scheduler;

    localparam int H = 4;
    localparam int G = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic [6:0] disp_data;
    logic       busy;
    logic [2:0] pending;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    key_display_scheduler #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .DEPTH      (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .disp_data (disp_data),
        .busy      (busy),
        .pending   (pending),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [6:0] bc [3];
    logic [6:0] fc [6];
    logic [6:0] exp_d;
    int         seg, off;

    initial begin
        bc[0] = 7'b0000001; bc[1] = 7'b0000010; bc[2] = 7'b0100000;
        fc[0] = 7'b0001000; fc[1] = 7'b0010000; fc[2] = 7'b1000000;
        fc[3] = 7'b0000001; fc[4] = 7'b0000100; fc[5] = 7'b0000010;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 7'b0;
        steps(2);
        chk("rst_disp",    32'(disp_data), 32'h0);
        chk("rst_busy",    32'(busy),      32'h0);
        chk("rst_pending", 32'(pending),   32'h0);
        chk("rst_err",     32'(err),       32'h0);
        chk("rst_ready",   32'(in_ready),  32'h1);
        reset = 1'b0;
        step();

        // single push
        in_valid = 1'b1; in_data = 7'b0000100;
        step();
        in_valid = 1'b0;
        chk("single_pend_e1", 32'(pending),   32'h1);
        chk("single_disp_e1", 32'(disp_data), 32'h0);
        step();
        chk("single_pend_e2", 32'(pending),   32'h0);
        for (int k = 0; k < H; k++) begin
            chk("single_show", 32'(disp_data), 32'h04);
            chk("single_busy", 32'(busy),      32'h1);
            step();
        end
        for (int k = 0; k < G; k++) begin
            chk("single_gap_disp", 32'(disp_data), 32'h0);
            chk("single_gap_busy", 32'(busy),      32'h1);
            step();
        end
        chk("single_idle_busy", 32'(busy),      32'h0);
        chk("single_idle_disp", 32'(disp_data), 32'h0);

        // burst of three, back to back
        in_valid = 1'b1; in_data = bc[0];
        step();
        in_data = bc[1];
        step();
        chk("burst_e2_disp", 32'(disp_data), 32'(bc[0]));
        chk("burst_e2_pend", 32'(pending),   32'h1);
        in_data = bc[2];
        step();
        in_valid = 1'b0;
        chk("burst_e3_pend", 32'(pending), 32'h2);
        for (int k = 3; k < 20; k++) begin
            seg   = (k - 2) / 6;
            off   = (k - 2) % 6;
            exp_d = (off < 4) ? bc[seg] : 7'b0;
            chk("burst_disp", 32'(disp_data), 32'(exp_d));
            chk("burst_busy", 32'(busy),      32'h1);
            chk("burst_pend", 32'(pending),   (k < 8) ? 32'h2 : (k < 14) ? 32'h1 : 32'h0);
            step();
        end
        chk("burst_idle_busy", 32'(busy), 32'h0);
        step();

        // illegal codes
        in_valid = 1'b1; in_data = 7'b0000011;
        step();
        in_valid = 1'b0;
        chk("ill1_err",  32'(err),     32'h1);
        chk("ill1_pend", 32'(pending), 32'h0);
        step();
        chk("ill1_err_clr", 32'(err),       32'h0);
        chk("ill1_disp",    32'(disp_data), 32'h0);
        in_valid = 1'b1; in_data = 7'b0000000;
        step();
        in_valid = 1'b0;
        chk("ill2_err",  32'(err),     32'h1);
        chk("ill2_pend", 32'(pending), 32'h0);
        step();
        chk("ill2_err_clr", 32'(err),       32'h0);
        chk("ill2_disp",    32'(disp_data), 32'h0);
        chk("ill2_busy",    32'(busy),      32'h0);

        // full queue during SHOW
        in_valid = 1'b1; in_data = 7'b0000100;
        step();
        in_valid = 1'b0;
        step();
        chk("full_show", 32'(disp_data), 32'h04);
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = fc[k];
            step();
            chk("full_pend",  32'(pending),  (k < 4) ? 32'(k + 1) : (k == 4) ? 32'h4 : 32'h3);
            chk("full_ready", 32'(in_ready), (k == 3 || k == 4) ? 32'h0 : 32'h1);
            chk("full_err",   32'(err),      32'h0);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("full_order", 32'(disp_data), 32'(fc[c]));
            steps(6);
        end
        chk("full_idle_busy", 32'(busy),      32'h0);
        chk("full_idle_disp", 32'(disp_data), 32'h0);
        chk("full_idle_pend", 32'(pending),   32'h0);

        // simultaneous push and pop on the GAP-to-SHOW edge
        in_valid = 1'b1; in_data = 7'b0010000;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; in_data = 7'b0100000;
        step();
        in_valid = 1'b0;
        steps(4);
        chk("sim_pend_gap", 32'(pending),   32'h1);
        chk("sim_disp_gap", 32'(disp_data), 32'h0);
        in_valid = 1'b1; in_data = 7'b1000000;
        step();
        in_valid = 1'b0;
        chk("sim_pend_pop", 32'(pending),   32'h1);
        chk("sim_disp_b",   32'(disp_data), 32'h20);
        steps(6);
        chk("sim_disp_c",   32'(disp_data), 32'h40);
        chk("sim_pend_end", 32'(pending),   32'h0);
        steps(6);
        chk("sim_idle_busy", 32'(busy), 32'h0);

        // reset mid-SHOW with two codes pending
        in_valid = 1'b1; in_data = bc[0];
        step();
        in_data = bc[1];
        step();
        in_data = bc[2];
        step();
        in_valid = 1'b0;
        chk("rst2_pre_pend", 32'(pending),   32'h2);
        chk("rst2_pre_disp", 32'(disp_data), 32'(bc[0]));
        #2;
        reset = 1'b1;
        #1;
        chk("rst2_disp",  32'(disp_data), 32'h0);
        chk("rst2_pend",  32'(pending),   32'h0);
        chk("rst2_busy",  32'(busy),      32'h0);
        chk("rst2_ready", 32'(in_ready),  32'h1);
        steps(2);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("rst2_post_disp", 32'(disp_data), 32'h0);
            chk("rst2_post_pend", 32'(pending),   32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
